emissions_monitor_mc: RTL and testbench
=======================================

Name: emissions_monitor_mc

Overview:
- Multi-channel, parametrised successor of the single-sensor CO2 threshold FSM.
- Accepts time-multiplexed emission samples tagged by channel and keeps one classification FSM per channel (IDLE/NORMAL/WARN/CRIT).
- Adds per-channel hysteresis, persistence debounce and aggregate alarm outputs.
- Sits between the sensor-sampling front end and the vehicle alarm/telemetry logic.

Parameters:
- NUM_CH, 4, number of monitored channels (>=1).
- DATA_W, 8, sample width in bits (unsigned).
- WARN_TH, 50, warning threshold; sample >= WARN_TH is warning level.
- CRIT_TH, 100, critical threshold; must be > WARN_TH.
- HYST, 5, de-escalation hysteresis; must be < WARN_TH.
- PERSIST, 3, consecutive qualifying samples needed to change level (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- sample_valid  input  1  sample_ch/sample_data valid this cycle; no back-pressure, every valid cycle is consumed.
- sample_ch  input  max(1,$clog2(NUM_CH))  target channel.
- sample_data  input  DATA_W  emission reading.
- ack  input  NUM_CH  per-channel latched-alarm clear.
- warning  output  NUM_CH  channel in WARN.
- critical  output  NUM_CH  channel in CRIT.
- any_warning  output  1  OR of warning.
- any_critical  output  1  OR of critical.
- alarm_latched  output  NUM_CH  sticky critical flag (see Optional Feature).

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-high. On reset every channel goes to CH_IDLE, pending target CH_NORMAL, counter 0. All outputs are 0. Reset mid-operation discards all pending counts.
- Sample routing: a sample is accepted only when sample_valid=1 and sample_ch < NUM_CH. Out-of-range channels are ignored. Only the addressed channel's state and counter can change.
- CH_IDLE:
  - data == 0 is ignored.
  - data != 0 moves the channel to CH_NORMAL.
  - The same sample is also evaluated as below, from a NORMAL baseline.
- Target level for an accepted sample, given the current level:
  - From NORMAL or IDLE: CRIT if data >= CRIT_TH; else WARN if data >= WARN_TH; else NORMAL.
  - From WARN: CRIT if data >= CRIT_TH; else NORMAL if data < WARN_TH-HYST; else WARN.
  - From CRIT: stay CRIT if data >= CRIT_TH-HYST; else WARN if data >= WARN_TH; else NORMAL if data < WARN_TH-HYST; else WARN.
- Debounce:
  - If target == current level: counter := 0.
  - If target != current and target == pending target: counter increments.
  - Otherwise: pending target := target and counter := 1.
  - When the counter reaches PERSIST, level := target and counter := 0.
  - With PERSIST=1 every change is immediate.
- Sample ordering: samples for other channels do not break a channel's consecutive run. Invalid cycles do not break it either.
- Latency: warning and critical are registered. They reflect the new level in the cycle after the PERSIST-th qualifying sample is accepted. any_* are combinational ORs of the registered bits.
- Output encoding: warning and critical are never both 1 for a channel. IDLE and NORMAL both drive 0.
- Arithmetic: compare unsigned at DATA_W. Threshold minus HYST is computed at elaboration; no runtime subtraction. The counter is $clog2(PERSIST+1) bits and saturates at PERSIST.
- Channel lifetime: once a channel leaves IDLE it never returns except through reset.

Optional Feature:
- Macro: EMISSIONS_ALARM_LATCH_EN.
- Defined:
  - alarm_latched[c] sets in the cycle the channel enters CRIT.
  - It stays set after the channel de-escalates.
  - It clears on ack[c]=1.
  - Set wins over simultaneous ack.
  - Reset clears it.
- Undefined: alarm_latched is tied to 0 and ack is ignored. The ports remain present.

Decomposition:
- Shared package emissions_pkg:
  - ch_state_t, a 2-bit enum {CH_IDLE, CH_NORMAL, CH_WARN, CH_CRIT}.
  - Helper function classifying a sample given the current state and the threshold constants.
- Sub-module emissions_channel_fsm:
  - Holds one channel's level, pending target, counter and latch.
  - Instantiated NUM_CH times in a generate loop.
  - The top level does address decode and the OR reductions.

Test Plan:
1. IDLE exit: reset, then ch0 samples 0,0 -> all outputs 0 and ch0 stays IDLE. Then ch0=20 -> NORMAL; warning[0]=0.
2. Debounce: ch1 samples 60,60,30,60,60 -> warning[1] never asserts. Then one more 60 -> warning[1]=1 the next cycle and any_warning=1.
3. Hysteresis: ch2 in WARN; 47 x5 -> stays WARN. Then 44 x3 -> warning[2]=0 after the third.
4. Mixed escalation: ch3 NORMAL, samples 60,120,120 -> still NORMAL. A fourth 120 -> critical[3]=1, warning[3]=0, any_critical=1.
5. Interleave and reset: ch0 60, ch1 10, ch0 60, ch0 60 -> warning[0]=1 and ch1 unchanged. Then assert reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
6. Latch (macro defined): ch0 reaches CRIT, then falls to 10 x3 -> critical[0]=0 but alarm_latched[0]=1. ack[0] -> 0. Ack in the same cycle as a new CRIT entry -> stays 1. With the macro undefined, alarm_latched is always 0.

Source files
------------

// File: rtl/emissions_pkg.sv
// Shared types and the per-sample level classifier for the multi-channel emissions monitor.
package emissions_pkg;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_NORMAL = 2'd1,
        CH_WARN   = 2'd2,
        CH_CRIT   = 2'd3
    } ch_state_t;

    localparam int CLS_W = 32;

    // Target level for one sample. The de-escalation thresholds (warn_lo, crit_lo)
    // already have the hysteresis subtracted by the caller at elaboration.
    function automatic ch_state_t classify(
        input ch_state_t          cur,
        input logic [CLS_W-1:0]   data,
        input logic [CLS_W-1:0]   warn_th,
        input logic [CLS_W-1:0]   crit_th,
        input logic [CLS_W-1:0]   warn_lo,
        input logic [CLS_W-1:0]   crit_lo
    );
        ch_state_t tgt;
        tgt = CH_NORMAL;
        case (cur)
            CH_WARN: begin
                if (data >= crit_th)      tgt = CH_CRIT;
                else if (data < warn_lo)  tgt = CH_NORMAL;
                else                      tgt = CH_WARN;
            end
            CH_CRIT: begin
                if (data >= crit_lo)      tgt = CH_CRIT;
                else if (data >= warn_th) tgt = CH_WARN;
                else if (data < warn_lo)  tgt = CH_NORMAL;
                else                      tgt = CH_WARN;
            end
            default: begin
                if (data >= crit_th)      tgt = CH_CRIT;
                else if (data >= warn_th) tgt = CH_WARN;
                else                      tgt = CH_NORMAL;
            end
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/emissions_monitor_mc_channel.sv
// One channel of the emissions monitor: level FSM, debounce counter and sticky critical flag.
// The sticky flag exists only when EMISSIONS_ALARM_LATCH_EN is defined.
module emissions_channel_fsm
    import emissions_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int WARN_TH = 50,
    parameter int CRIT_TH = 100,
    parameter int HYST    = 5,
    parameter int PERSIST = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic [DATA_W-1:0] data,
    input  logic              ack,
    output logic              warning,
    output logic              critical,
    output logic              alarm_latched
);

    localparam int CNT_W = $clog2(PERSIST + 1);
    localparam logic [DATA_W-1:0] WARN_V  = DATA_W'(WARN_TH);
    localparam logic [DATA_W-1:0] CRIT_V  = DATA_W'(CRIT_TH);
    localparam logic [DATA_W-1:0] WARN_LO = DATA_W'(WARN_TH - HYST);
    localparam logic [DATA_W-1:0] CRIT_LO = DATA_W'(CRIT_TH - HYST);
    localparam logic [CNT_W-1:0]  PERSIST_V = CNT_W'(PERSIST);

    ch_state_t        level, level_nxt;
    ch_state_t        pending, pending_nxt;
    ch_state_t        base, target;
    logic [CNT_W-1:0] count, count_nxt, cnt_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level    <= CH_IDLE;
            pending  <= CH_NORMAL;
            count    <= '0;
            warning  <= 1'b0;
            critical <= 1'b0;
        end else begin
            level    <= level_nxt;
            pending  <= pending_nxt;
            count    <= count_nxt;
            warning  <= (level_nxt == CH_WARN);
            critical <= (level_nxt == CH_CRIT);
        end
    end

    // An idle channel treats its first non-zero sample as arriving at a NORMAL baseline.
    always_comb begin
        level_nxt   = level;
        pending_nxt = pending;
        count_nxt   = count;
        base        = level;
        target      = level;
        cnt_inc     = '0;
        if (accept && !(level == CH_IDLE && data == '0)) begin
            base      = (level == CH_IDLE) ? CH_NORMAL : level;
            target    = classify(base, CLS_W'(data), CLS_W'(WARN_V), CLS_W'(CRIT_V),
                                 CLS_W'(WARN_LO), CLS_W'(CRIT_LO));
            level_nxt = base;
            cnt_inc   = (count >= PERSIST_V) ? PERSIST_V : count + CNT_W'(1);
            if (target == base) begin
                count_nxt = '0;
            end else if (target == pending) begin
                if (cnt_inc == PERSIST_V) begin
                    level_nxt = target;
                    count_nxt = '0;
                end else begin
                    count_nxt = cnt_inc;
                end
            end else begin
                pending_nxt = target;
                if (PERSIST_V == CNT_W'(1)) begin
                    level_nxt = target;
                    count_nxt = '0;
                end else begin
                    count_nxt = CNT_W'(1);
                end
            end
        end
    end

`ifdef EMISSIONS_ALARM_LATCH_EN
    logic enter_crit;
    assign enter_crit = (level != CH_CRIT) && (level_nxt == CH_CRIT);

    // Entry into CRIT takes priority over a simultaneous acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           alarm_latched <= 1'b0;
        else if (enter_crit) alarm_latched <= 1'b1;
        else if (ack)        alarm_latched <= 1'b0;
    end
`else
    logic unused_ack;
    assign unused_ack    = ack;
    assign alarm_latched = 1'b0;
`endif

endmodule

// File: rtl/emissions_monitor_mc.sv
// Multi-channel emissions monitor: routes tagged samples to per-channel FSMs and ORs the alarms.
// Optional sticky alarm flags are enabled with EMISSIONS_ALARM_LATCH_EN.
module emissions_monitor_mc
    import emissions_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int WARN_TH = 50,
    parameter int CRIT_TH = 100,
    parameter int HYST    = 5,
    parameter int PERSIST = 3,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [CH_W-1:0]   sample_ch,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] warning,
    output logic [NUM_CH-1:0] critical,
    output logic              any_warning,
    output logic              any_critical,
    output logic [NUM_CH-1:0] alarm_latched
);

    logic [NUM_CH-1:0] accept;

    // Out-of-range channel numbers match no decoder and are therefore dropped.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign accept[c] = sample_valid && (sample_ch == CH_W'(c));

        emissions_channel_fsm #(
            .DATA_W  (DATA_W),
            .WARN_TH (WARN_TH),
            .CRIT_TH (CRIT_TH),
            .HYST    (HYST),
            .PERSIST (PERSIST)
        ) u_fsm (
            .clk           (clk),
            .reset         (reset),
            .accept        (accept[c]),
            .data          (sample_data),
            .ack           (ack[c]),
            .warning       (warning[c]),
            .critical      (critical[c]),
            .alarm_latched (alarm_latched[c])
        );
    end

    assign any_warning  = |warning;
    assign any_critical = |critical;

endmodule

// File: tb/tb_emissions_monitor_mc.sv
// Self-checking bench for emissions_monitor_mc (default parameters, 4 channels).
// Expected sticky flags are masked to 0 unless EMISSIONS_ALARM_LATCH_EN is defined.
module tb_emissions_monitor_mc;

`ifdef EMISSIONS_ALARM_LATCH_EN
    localparam bit LATCH_ON = 1'b1;
`else
    localparam bit LATCH_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [1:0] sample_ch;
    logic [7:0] sample_data;
    logic [3:0] ack;
    logic [3:0] warning, critical, alarm_latched;
    logic       any_warning, any_critical;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       valid;
        logic [1:0] ch;
        logic [7:0] data;
        logic [3:0] ack;
        logic [3:0] w;
        logic [3:0] c;
        logic [3:0] l;
    } vec_t;

    typedef struct {
        logic [3:0] w;
        logic [3:0] c;
        logic [3:0] l;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    emissions_monitor_mc dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_ch     (sample_ch),
        .sample_data   (sample_data),
        .ack           (ack),
        .warning       (warning),
        .critical      (critical),
        .any_warning   (any_warning),
        .any_critical  (any_critical),
        .alarm_latched (alarm_latched)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [7:0] d,
                                input logic [3:0] a, input logic [3:0] w, input logic [3:0] c,
                                input logic [3:0] l);
        vec_t r;
        r.valid = v; r.ch = ch; r.data = d; r.ack = a; r.w = w; r.c = c; r.l = l;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic cmpAll(input string name, input logic [3:0] w, input logic [3:0] c,
                          input logic [3:0] l);
        logic [3:0] lm;
        lm = LATCH_ON ? l : 4'b0000;
        cmp({name, " warning"}, warning, w);
        cmp({name, " critical"}, critical, c);
        cmp({name, " any_warning"}, {3'b000, any_warning}, {3'b000, |w});
        cmp({name, " any_critical"}, {3'b000, any_critical}, {3'b000, |c});
        cmp({name, " alarm_latched"}, alarm_latched, lm);
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: scoreboard empty, got none, want one entry", name);
            return;
        end
        e = sb.pop_front();
        cmpAll(name, e.w, e.c, e.l);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        sample_valid = v.valid;
        sample_ch    = v.ch;
        sample_data  = v.data;
        ack          = v.ack;
        e.w = v.w; e.c = v.c; e.l = v.l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_ch    = 2'd0;
        sample_data  = 8'd0;
        ack          = 4'b0000;

        // IDLE exit, debounce, hysteresis, mixed escalation, sticky flag and ack
        vecs.push_back(mk(1, 0,   0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 0,   0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 0,  20, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 1,  60, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 1,  60, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 1,  30, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 1,  60, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 1,  60, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 1,  60, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 2,  60, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 2,  60, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 2,  60, 4'b0000, 4'b0110, 4'b0000, 4'b0000));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 2, 47, 4'b0000, 4'b0110, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 2,  44, 4'b0000, 4'b0110, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 2,  44, 4'b0000, 4'b0110, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 2,  44, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 3,  20, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 3,  60, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 3, 120, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 3, 120, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 3, 200, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 0,  20, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        vecs.push_back(mk(1, 3, 120, 4'b0000, 4'b0010, 4'b1000, 4'b1000));
        vecs.push_back(mk(1, 0, 120, 4'b0000, 4'b0010, 4'b1000, 4'b1000));
        vecs.push_back(mk(1, 0, 120, 4'b0000, 4'b0010, 4'b1000, 4'b1000));
        vecs.push_back(mk(1, 0, 120, 4'b0000, 4'b0010, 4'b1001, 4'b1001));
        vecs.push_back(mk(1, 0,  10, 4'b0000, 4'b0010, 4'b1001, 4'b1001));
        vecs.push_back(mk(1, 0,  10, 4'b0000, 4'b0010, 4'b1001, 4'b1001));
        vecs.push_back(mk(1, 0,  10, 4'b0000, 4'b0010, 4'b1000, 4'b1001));
        vecs.push_back(mk(0, 0,   0, 4'b0001, 4'b0010, 4'b1000, 4'b1000));
        vecs.push_back(mk(1, 0, 120, 4'b0000, 4'b0010, 4'b1000, 4'b1000));
        vecs.push_back(mk(1, 0, 120, 4'b0000, 4'b0010, 4'b1000, 4'b1000));
        vecs.push_back(mk(1, 0, 120, 4'b0001, 4'b0010, 4'b1001, 4'b1001));
        vecs.push_back(mk(0, 0,   0, 4'b0001, 4'b0010, 4'b1001, 4'b1000));
        vecs.push_back(mk(0, 0,   0, 4'b1000, 4'b0010, 4'b1001, 4'b0000));

        repeat (2) @(posedge clk);
        #1;
        cmpAll("reset state", 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Interleaved channels, then an asynchronous reset in the middle of a run
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        applyStimulus(mk(1, 0, 60, 4'b0000, 4'b0000, 4'b0000, 4'b0000), "il ch0 a");
        applyStimulus(mk(1, 1, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0000), "il ch1");
        applyStimulus(mk(1, 0, 60, 4'b0000, 4'b0000, 4'b0000, 4'b0000), "il ch0 b");
        applyStimulus(mk(0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000), "il gap");
        applyStimulus(mk(1, 0, 60, 4'b0000, 4'b0001, 4'b0000, 4'b0000), "il ch0 c");
        applyStimulus(mk(1, 1, 60, 4'b0000, 4'b0001, 4'b0000, 4'b0000), "il ch1 a");
        applyStimulus(mk(1, 1, 60, 4'b0000, 4'b0001, 4'b0000, 4'b0000), "il ch1 b");

        @(negedge clk);
        sample_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        cmpAll("async reset", 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        // A pending count from before reset must not carry over
        applyStimulus(mk(1, 1, 60, 4'b0000, 4'b0000, 4'b0000, 4'b0000), "post rst 1");
        applyStimulus(mk(1, 1, 60, 4'b0000, 4'b0000, 4'b0000, 4'b0000), "post rst 2");
        applyStimulus(mk(1, 1, 60, 4'b0000, 4'b0010, 4'b0000, 4'b0000), "post rst 3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
